pipe_field: RTL and testbench

- Downstream of the bird stage; consumes the 16-bit one-hot bird position (bit 0 = ground, bit 15 = ceiling).
- Generates scrolling two-column-wide pipes with a 3-row gap, with gap position chosen by an LFSR.
- Detects collisions, keeps the score and runs the game state machine (IDLE/RUN/OVER).
- Drives a column frame buffer consumed by the LED display driver.

---
 rtl/pipe_field.sv | 157 +++++++++++++++
 tb/tb_pipe_field.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_field.sv
`default_nettype none
// ============================================================================
// Module      : pipe_field
// Description : Scrolling pipe playfield for the flappy-bird game. It spawns
//               two-column pipes with an LFSR-placed 3-row gap, detects bird
//               collisions, keeps the score and runs the IDLE/RUN/OVER game
//               state machine. It also drives the column frame buffer read by
//               the LED display driver.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_field #(
    parameter int NCOLS    = 8,
    parameter int BIRD_COL = 2,
    parameter int SPACING  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 start,
    input  logic [15:0]          bird_pos,
    output logic [NCOLS*16-1:0]  cols,
    output logic                 collision,
    output logic                 game_over,
    output logic                 running,
    output logic [7:0]           score
);

    localparam int                CNT_W       = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam logic [7:0]        c_lfsr_seed = 8'hA5;
    localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(SPACING - 1);
    localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t              r_state;
    logic [7:0]          r_lfsr;
    logic [CNT_W-1:0]    r_spawn_cnt;
    logic [15:0]         r_wall_latch;
    logic [NCOLS-1:0]    r_tags;

    logic [3:0]          w_gap_idx;
    logic [15:0]         w_wall;
    logic [15:0]         w_new_col;
    logic                w_new_tag;
    logic                w_lfsr_fb;
    logic [15:0]         w_bird_col;
    logic                w_scroll;
    logic                w_clear;
    logic                w_unused_tag;

    // Fold the 4-bit LFSR slice into 0..13 so the 3-row gap always fits.
    always_comb begin
        w_gap_idx = r_lfsr[3:0];
        if (w_gap_idx >= 4'd14) begin
            w_gap_idx = w_gap_idx - 4'd14;
        end
    end

    assign w_wall    = ~(16'h0007 << w_gap_idx);
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Pick the column entering at the right edge from the spawn phase.
    always_comb begin
        w_new_col = 16'h0000;
        w_new_tag = 1'b0;
        if (r_spawn_cnt == '0) begin
            w_new_col = w_wall;
        end else if (r_spawn_cnt == c_cnt_one) begin
            w_new_col = r_wall_latch;
            w_new_tag = 1'b1;
        end
    end

    assign w_bird_col = cols[BIRD_COL*16 +: 16];
    assign collision  = running & (((w_bird_col & bird_pos) != 16'h0000) | bird_pos[0]);

    // A collision on the same edge as a tick wins: the field freezes as it is.
    assign w_scroll = (r_state == S_RUN) & tick & ~collision;
    assign w_clear  = (r_state == S_OVER) & start;

    // The leftmost tag leaves the field without being looked at.
    assign w_unused_tag = r_tags[0];

    // Game state machine with registered status outputs and score keeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            running   <= 1'b0;
            game_over <= 1'b0;
            score     <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        running <= 1'b1;
                        score   <= 8'h00;
                    end
                end
                S_RUN: begin
                    if (collision) begin
                        r_state   <= S_OVER;
                        running   <= 1'b0;
                        game_over <= 1'b1;
                    end else if (w_scroll && r_tags[BIRD_COL] && (score != 8'hFF)) begin
                        score <= score + 8'h01;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        r_state   <= S_IDLE;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    running   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

    // Field datapath: column/tag shift, spawn phase counter and gap LFSR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cols         <= '0;
            r_tags       <= '0;
            r_spawn_cnt  <= '0;
            r_wall_latch <= 16'h0000;
            r_lfsr       <= c_lfsr_seed;
        end else if (w_clear || ((r_state == S_IDLE) && start)) begin
            // Leaving OVER wipes the field; the LFSR keeps running so games differ.
            cols        <= '0;
            r_tags      <= '0;
            r_spawn_cnt <= '0;
        end else if (w_scroll) begin
            cols   <= {w_new_col, cols[NCOLS*16-1:16]};
            r_tags <= {w_new_tag, r_tags[NCOLS-1:1]};
            if (r_spawn_cnt == '0) begin
                r_wall_latch <= w_wall;
                r_lfsr       <= {r_lfsr[6:0], w_lfsr_fb};
            end
            if (r_spawn_cnt == c_cnt_last) begin
                r_spawn_cnt <= '0;
            end else begin
                r_spawn_cnt <= r_spawn_cnt + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_field.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_field
// Description : Self-checking bench for pipe_field: directed vector table,
//               hand sequences for multi-cycle corners, and random stimulus
//               compared against a behavioural playfield model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_field;

    localparam int NCOLS    = 8;
    localparam int BIRD_COL = 2;
    localparam int SPACING  = 5;
    localparam int W        = NCOLS * 16;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          tick     = 1'b0;
    logic          start    = 1'b0;
    logic [15:0]   bird_pos = 16'h0000;
    logic [W-1:0]  cols;
    logic          collision;
    logic          game_over;
    logic          running;
    logic [7:0]    score;

    int checks   = 0;
    int failures = 0;

    pipe_field #(
        .NCOLS    (NCOLS),
        .BIRD_COL (BIRD_COL),
        .SPACING  (SPACING)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .bird_pos  (bird_pos),
        .cols      (cols),
        .collision (collision),
        .game_over (game_over),
        .running   (running),
        .score     (score)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: the field is described by the number of scrolls
    // since the game began and the list of pipe walls spawned so far.
    // ------------------------------------------------------------------
    int           m_state;   // 0 idle, 1 run, 2 over
    int           m_n;
    logic [7:0]   m_lfsr;
    logic [7:0]   m_score;
    logic [15:0]  m_walls[$];

    function automatic logic [15:0] wall_from(input logic [7:0] l);
        int g;
        g = int'(l & 8'h0F);
        if (g >= 14) g = g - 14;
        return ~(16'h0007 << g);
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Column i holds whatever entered at scroll number k (1-based).
    function automatic logic [15:0] exp_col(input int i);
        int k;
        k = m_n - (NCOLS - 1 - i);
        if (k < 1) return 16'h0000;
        if (((k - 1) % SPACING) <= 1) return m_walls[(k - 1) / SPACING];
        return 16'h0000;
    endfunction

    function automatic logic [W-1:0] exp_cols();
        logic [W-1:0] v;
        for (int i = 0; i < NCOLS; i++) v[16*i +: 16] = exp_col(i);
        return v;
    endfunction

    function automatic logic exp_collision(input logic [15:0] b);
        return (m_state == 1) && (((exp_col(BIRD_COL) & b) != 16'h0000) || b[0]);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_n     = 0;
        m_lfsr  = 8'hA5;
        m_score = 8'h00;
        m_walls.delete();
    endtask

    task automatic model_edge(input logic t, input logic s, input logic [15:0] b);
        int thr;
        int cnt;
        case (m_state)
            0: if (s) begin
                m_state = 1;
                m_n     = 0;
                m_score = 8'h00;
                m_walls.delete();
            end
            1: if (exp_collision(b)) begin
                m_state = 2;
            end else if (t) begin
                m_n = m_n + 1;
                if (((m_n - 1) % SPACING) == 0) begin
                    m_walls.push_back(wall_from(m_lfsr));
                    m_lfsr = lfsr_next(m_lfsr);
                end
                // Pipe p is counted once its trailing column has scrolled off the bird column.
                thr = 2 + NCOLS - BIRD_COL;
                cnt = (m_n >= thr) ? ((m_n - thr) / SPACING + 1) : 0;
                m_score = (cnt > 255) ? 8'hFF : 8'(cnt);
            end
            default: if (s) begin
                m_state = 0;
                m_n     = 0;
                m_walls.delete();
            end
        endcase
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic compare_all();
        chk("cols", cols, exp_cols());
        chk("score", score, m_score);
        chk("running", running, m_state == 1);
        chk("game_over", game_over, m_state == 2);
        chk("collision_post", collision, exp_collision(bird_pos));
    endtask

    // One clock cycle: drive on the falling edge, check collision before the
    // rising edge, advance the model and check everything after it.
    task automatic step(input logic t, input logic s, input logic [15:0] b);
        @(negedge clk);
        tick     = t;
        start    = s;
        bird_pos = b;
        #1;
        chk("collision_pre", collision, exp_collision(b));
        @(posedge clk);
        model_edge(t, s, b);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        tick  = 1'b0;
        start = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [15:0] safe_bird();
        logic [15:0] c;
        c = exp_col(BIRD_COL);
        if (c == 16'h0000) return 16'h0001 << $urandom_range(1, 15);
        for (int r = 15; r >= 1; r--) if (!c[r]) return 16'h0001 << r;
        return 16'h0002;
    endfunction

    // ------------------------------------------------------------------
    // Directed vector table: applied from reset with the bird at row 6.
    // ------------------------------------------------------------------
    typedef struct {
        logic        t;
        logic        s;
        logic [15:0] b;
        logic        run;
        logic        over;
        logic [7:0]  sc;
        logic [15:0] c7;
        logic [15:0] c6;
        logic [15:0] c2;
    } vec_t;

    vec_t tbl[10];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [W-1:0] snap;
        int           cyc;

        tbl[0] = '{1'b1, 1'b0, 16'h0040, 1'b0, 1'b0, 8'd0, 16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 16'h0040, 1'b1, 1'b0, 8'd0, 16'h0000, 16'h0000, 16'h0000};
        tbl[2] = '{1'b1, 1'b0, 16'h0040, 1'b1, 1'b0, 8'd0, 16'hFF1F, 16'h0000, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 16'h0040, 1'b1, 1'b0, 8'd0, 16'hFF1F, 16'hFF1F, 16'h0000};
        tbl[4] = '{1'b1, 1'b1, 16'h0040, 1'b1, 1'b0, 8'd0, 16'h0000, 16'hFF1F, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, 16'h0040, 1'b1, 1'b0, 8'd0, 16'h0000, 16'h0000, 16'h0000};
        tbl[6] = '{1'b1, 1'b0, 16'h0040, 1'b1, 1'b0, 8'd0, 16'h0000, 16'h0000, 16'h0000};
        tbl[7] = '{1'b1, 1'b0, 16'h0040, 1'b1, 1'b0, 8'd0, 16'hE3FF, 16'h0000, 16'hFF1F};
        tbl[8] = '{1'b1, 1'b0, 16'h0040, 1'b1, 1'b0, 8'd0, 16'hE3FF, 16'hE3FF, 16'hFF1F};
        tbl[9] = '{1'b1, 1'b0, 16'h0040, 1'b1, 1'b0, 8'd1, 16'h0000, 16'hE3FF, 16'h0000};

        // Reset held while the strobes toggle.
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tick  = i[0];
            start = ~i[0];
            @(posedge clk);
            #1;
            chk("reset_cols", cols, '0);
            chk("reset_score", score, 8'h00);
            chk("reset_running", running, 1'b0);
            chk("reset_game_over", game_over, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        tick  = 1'b0;
        step(1'b0, 1'b1, 16'h0040);
        chk("start_running", running, 1'b1);

        // Vector table from a fresh reset.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].t, tbl[i].s, tbl[i].b);
            chk($sformatf("vec%0d_running", i), running, tbl[i].run);
            chk($sformatf("vec%0d_game_over", i), game_over, tbl[i].over);
            chk($sformatf("vec%0d_score", i), score, tbl[i].sc);
            chk($sformatf("vec%0d_col7", i), cols[(NCOLS-1)*16 +: 16], tbl[i].c7);
            chk($sformatf("vec%0d_col6", i), cols[(NCOLS-2)*16 +: 16], tbl[i].c6);
            chk($sformatf("vec%0d_col2", i), cols[2*16 +: 16], tbl[i].c2);
        end

        // Wall hit: bird at row 8 meets the first pipe after six scrolls.
        do_reset();
        step(1'b0, 1'b1, 16'h0100);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0100);
        chk("wall_collision", collision, 1'b1);
        step(1'b1, 1'b0, 16'h0100);
        chk("wall_game_over", game_over, 1'b1);
        chk("wall_running", running, 1'b0);
        chk("wall_col2", cols[2*16 +: 16], 16'hFF1F);
        snap = cols;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0100);
        chk("wall_frozen_cols", cols, snap);
        chk("wall_frozen_score", score, 8'h00);

        // Ground hit with tick in the same cycle, then restart.
        do_reset();
        step(1'b0, 1'b1, 16'h0040);
        step(1'b1, 1'b0, 16'h0040);
        step(1'b1, 1'b0, 16'h0040);
        snap = cols;
        step(1'b1, 1'b0, 16'h0001);
        chk("ground_game_over", game_over, 1'b1);
        chk("ground_no_scroll", cols, snap);
        step(1'b0, 1'b1, 16'h0040);
        chk("over_to_idle_cols", cols, '0);
        chk("over_to_idle_game_over", game_over, 1'b0);
        step(1'b0, 1'b1, 16'h0040);
        chk("restart_running", running, 1'b1);
        chk("restart_score", score, 8'h00);
        step(1'b1, 1'b0, 16'h0040);
        chk("restart_new_gap", cols[(NCOLS-1)*16 +: 16], 16'hE3FF);

        // Asynchronous reset between clock edges.
        do_reset();
        step(1'b0, 1'b1, 16'h0040);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 16'h0040);
        chk("pre_async_score", score, 8'h01);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_cols", cols, '0);
        chk("async_score", score, 8'h00);
        chk("async_running", running, 1'b0);
        chk("async_collision", collision, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b1, 16'h0040);
        step(1'b1, 1'b0, 16'h0040);
        chk("async_seed_restored", cols[(NCOLS-1)*16 +: 16], 16'hFF1F);

        // Random stimulus against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            int r;
            logic [15:0] b;
            r = $urandom_range(0, 9);
            if (r == 0)      b = 16'h0000;
            else if (r == 1) b = 16'($urandom);
            else if (r <= 5) b = safe_bird();
            else             b = 16'h0001 << $urandom_range(0, 15);
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), b);
        end

        // Autopilot flight to score saturation.
        do_reset();
        step(1'b0, 1'b1, 16'h0040);
        cyc = 0;
        while (m_score != 8'hFF && cyc < 4000) begin
            step(($urandom_range(0, 3) != 0), 1'b0, safe_bird());
            cyc++;
        end
        chk("score_saturated", score, 8'hFF);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, safe_bird());
        chk("score_stays_saturated", score, 8'hFF);
        chk("autopilot_running", running, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
